// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ requesters.
// Latency: req sampled high in cycle t -> gnt/wrEn/wrAddr/wrData registered and visible in t+1.
// Backpressure: requesters hold req/addr/data until their one-cycle gnt pulse; busy flags a losing eligible requester.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset (asserted when 0)
//   req      per-requester level write request, held until granted
//   reqAddr  packed target indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   reqData  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt      registered one-hot grant pulse to the winner
//   wrEn     registered register-file write enable
//   wrAddr   registered register-file write index
//   wrData   registered register-file write data
//   busy     combinational: some eligible requester loses this cycle
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqData,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             wrEn,
  output logic [ADDR_WIDTH-1:0]            wrAddr,
  output logic [DATA_WIDTH-1:0]            wrData,
  output logic                             busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        offset;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W-1:0]        ptr_nxt;
  logic [PTR_W:0]          sum;
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      rot;
  logic [NUM_REQ-1:0]      win_oh;
  logic [2*NUM_REQ-1:0]    dbl;
  logic                    any_elig;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  // A requester whose grant is visible this cycle is masked so a request
  // that has not been dropped yet cannot win twice in a row.
  assign elig     = req & ~gnt;
  assign any_elig = |elig;

  // Rotate the eligible vector so bit k corresponds to requester (ptr+k) mod NUM_REQ;
  // the first set bit then gives the winner's distance from the pointer.
  assign dbl = {elig, elig} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        offset = PTR_W'(k);
        found  = 1'b1;
      end
    end
  end

  // winner = (ptr + offset) mod NUM_REQ; one spare bit keeps the sum exact
  // so non-power-of-two NUM_REQ wraps correctly.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PTR_W+1)'(NUM_REQ)) begin
      sum = sum - (PTR_W+1)'(NUM_REQ);
    end
    winner = sum[PTR_W-1:0];
  end

  assign ptr_nxt = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
  assign win_oh  = any_elig ? (NUM_REQ'(1) << winner) : '0;
  assign busy    = |(elig & ~win_oh);

  // One-hot mux of the winning lane's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_addr = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt    <= '0;
      wrEn   <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
      ptr    <= '0;
    end else if (any_elig) begin
      gnt    <= win_oh;
      wrEn   <= 1'b1;
      wrAddr <= sel_addr;
      wrData <= sel_data;
      ptr    <= ptr_nxt;
    end else begin
      // Address/data hold; they are don't-care while wrEn is low.
      gnt    <= '0;
      wrEn   <= 1'b0;
    end
  end

endmodule
